dmem_bridge: RTL and testbench

Data-memory bus bridge, directly downstream of the load/store unit. Takes the LSU's single-beat memory request (address, write data, byte enables, rd/wr strobes) and runs it as one transaction on an Avalon-MM-style master port with wait states and variable read latency. Stalls the core until the transaction completes, returns read data on the LSU's mem_rdata/mem_vld inputs, and flags a bus timeout.

---
 rtl/dmem_bridge_if.sv | 38 +++
 rtl/dmem_bridge.sv | 138 +++++++++++++
 tb/tb_dmem_bridge.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_if.sv
// LSU request/response and Avalon-MM master signals for dmem_bridge.
// The master modport is the bridge's view; slave is the LSU plus memory side.
interface dmem_bridge_if #(
  parameter int unsigned AW = 32
) ();
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_byte_en;
  logic [31:0]   mem_rdata;
  logic          mem_vld;
  logic          mem_err;
  logic          mem_stall;

  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic          avm_waitrequest;
  logic [31:0]   avm_readdata;
  logic          avm_readdatavalid;

  modport master (
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_byte_en,
    output mem_rdata, mem_vld, mem_err, mem_stall,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_byte_en,
    input  mem_rdata, mem_vld, mem_err, mem_stall,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/dmem_bridge.sv
// Runs one LSU memory request as a single Avalon-MM transaction, stalling the
// core until it completes; reports read data and bus timeouts.
module dmem_bridge #(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst_b,
  dmem_bridge_if.master bus
);
  localparam int unsigned CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    be_q, be_d;
  logic          is_wr_q, is_wr_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req;
  logic          timeout_hit;

  assign req         = bus.mem_rd | bus.mem_wr;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    is_wr_d = is_wr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = bus.mem_addr & ~AW'(3);
          wdata_d = bus.mem_wdata;
          be_d    = bus.mem_wr ? bus.mem_byte_en : 4'hF;
          is_wr_d = bus.mem_wr;
          rd_d    = ~bus.mem_wr;
          wr_d    = bus.mem_wr;
          cnt_d   = '0;
          state_d = CMD;
        end
      end
      CMD: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.avm_waitrequest && (is_wr_q || bus.avm_readdatavalid)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
          if (!is_wr_q) begin
            rdata_d = bus.avm_readdata;
            vld_d   = 1'b1;
          end
        end else if (timeout_hit) begin
          // Abort wins over a plain acceptance; any later response is dropped.
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
          if (!is_wr_q) begin
            rdata_d = ABORT_DATA;
            vld_d   = 1'b1;
          end
        end else if (!bus.avm_waitrequest) begin
          rd_d    = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.avm_readdatavalid) begin
          rdata_d = bus.avm_readdata;
          vld_d   = 1'b1;
          state_d = DONE;
        end else if (timeout_hit) begin
          rdata_d = ABORT_DATA;
          vld_d   = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      is_wr_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      is_wr_q <= is_wr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.avm_address    = addr_q;
  assign bus.avm_read       = rd_q;
  assign bus.avm_write      = wr_q;
  assign bus.avm_writedata  = wdata_q;
  assign bus.avm_byteenable = be_q;
  assign bus.mem_rdata      = rdata_q;
  assign bus.mem_vld        = vld_q;
  assign bus.mem_err        = err_q;
  assign bus.mem_stall      = (state_q == IDLE && req) || state_q == CMD || state_q == RESP;
endmodule

// File: tb/tb_dmem_bridge.sv
// Directed-vector bench for dmem_bridge; status vectors are {avm_read, avm_write,
// mem_vld, mem_err, mem_stall} per cycle, cycle 0 being the request's IDLE cycle.
module tb_dmem_bridge;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_b;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_bridge_if #(.AW(32)) bus ();
  dmem_bridge #(.AW(32), .TIMEOUT(TO)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input logic wreq,
                       input logic rdv, input logic [31:0] rdat);
    bus.mem_rd            = rd;
    bus.mem_wr            = wr;
    bus.mem_addr          = addr;
    bus.mem_wdata         = wd;
    bus.mem_byte_en       = be;
    bus.avm_waitrequest   = wreq;
    bus.avm_readdatavalid = rdv;
    bus.avm_readdata      = rdat;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [104:0] obs;
    rst_b = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    #2 rst_b = 1'b0;
    @(negedge clk);
    obs = {bus.avm_address, bus.avm_read, bus.avm_write, bus.avm_writedata,
           bus.avm_byteenable, bus.mem_rdata, bus.mem_vld, bus.mem_err, bus.mem_stall};
    n_vec++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got %h want 0", obs);
    end
    rst_b = 1'b1;
    next_cycle();
    n_vec++;
    if (bus.mem_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_stall: got %b want 0", bus.mem_stall);
    end
  endtask

  task automatic test_zero_wait_read();
    logic [4:0]  e_st [5] = '{5'b00001, 5'b10001, 5'b00100, 5'b00000, 5'b00000};
    logic [31:0] e_rd [5] = '{32'h0, 32'h0, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    logic        rd   [5] = '{1, 1, 1, 0, 0};
    logic        rdv  [5] = '{0, 1, 0, 0, 0};
    for (int c = 0; c < 5; c++) begin
      drive(rd[c], 0, 32'h0000_1004, 32'h0, 4'h0, 0, rdv[c], rdv[c] ? 32'h1234_5678 : 32'hFFFF_0000);
      @(negedge clk);
      n_vec++;
      if ({bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall} !== e_st[c]) begin
        n_bad++;
        $display("FAIL zw_read_status c%0d: got %b want %b", c,
                 {bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall}, e_st[c]);
      end
      n_vec++;
      if (bus.mem_rdata !== e_rd[c]) begin
        n_bad++;
        $display("FAIL zw_read_rdata c%0d: got %h want %h", c, bus.mem_rdata, e_rd[c]);
      end
      if (e_st[c][4]) begin
        n_vec++;
        if ({bus.avm_address, bus.avm_byteenable} !== {32'h0000_1004, 4'hF}) begin
          n_bad++;
          $display("FAIL zw_read_cmd c%0d: got %h/%h want 00001004/f", c, bus.avm_address, bus.avm_byteenable);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_write_wait();
    logic [4:0] e_st [7] = '{5'b00001, 5'b01001, 5'b01001, 5'b01001, 5'b01001, 5'b00000, 5'b00000};
    logic       wr   [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic       wreq [7] = '{1, 1, 1, 1, 0, 0, 0};
    for (int c = 0; c < 7; c++) begin
      drive(0, wr[c], 32'h0000_2003, 32'hABAB_ABAB, 4'b1000, wreq[c], 0, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall} !== e_st[c]) begin
        n_bad++;
        $display("FAIL wr_wait_status c%0d: got %b want %b", c,
                 {bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall}, e_st[c]);
      end
      n_vec++;
      if (bus.mem_rdata !== 32'h1234_5678) begin
        n_bad++;
        $display("FAIL wr_wait_rdata_held c%0d: got %h want 12345678", c, bus.mem_rdata);
      end
      if (e_st[c][3]) begin
        n_vec++;
        if ({bus.avm_address, bus.avm_byteenable, bus.avm_writedata} !== {32'h0000_2000, 4'b1000, 32'hABAB_ABAB}) begin
          n_bad++;
          $display("FAIL wr_wait_cmd c%0d: got %h/%h/%h want 00002000/8/abababab", c,
                   bus.avm_address, bus.avm_byteenable, bus.avm_writedata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_resp_read();
    logic [4:0]  e_st [8] = '{5'b00001, 5'b10001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00100, 5'b00000};
    logic [31:0] e_rd [8] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                              32'h1234_5678, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D};
    logic        rd   [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic        rdv  [8] = '{1, 0, 0, 0, 0, 1, 0, 0};
    for (int c = 0; c < 8; c++) begin
      drive(rd[c], 0, 32'h0000_3008, 32'h0, 4'h0, 0, rdv[c], (c == 5) ? 32'hCAFE_F00D : 32'hBAD0_BAD0);
      @(negedge clk);
      n_vec++;
      if ({bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall} !== e_st[c]) begin
        n_bad++;
        $display("FAIL resp_read_status c%0d: got %b want %b", c,
                 {bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall}, e_st[c]);
      end
      n_vec++;
      if (bus.mem_rdata !== e_rd[c]) begin
        n_bad++;
        $display("FAIL resp_read_rdata c%0d: got %h want %h", c, bus.mem_rdata, e_rd[c]);
      end
      if (e_st[c][4]) begin
        n_vec++;
        if ({bus.avm_address, bus.avm_byteenable} !== {32'h0000_3008, 4'hF}) begin
          n_bad++;
          $display("FAIL resp_read_cmd c%0d: got %h/%h want 00003008/f", c, bus.avm_address, bus.avm_byteenable);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    logic [4:0]  e_st;
    logic [31:0] e_rd;
    for (int c = 0; c < 12; c++) begin
      drive(c <= 9, 0, 32'h0000_4000, 32'h0, 4'h0, 1, (c == 3) || (c >= 10), 32'h1111_1111);
      e_st = (c == 0) ? 5'b00001 : (c <= 8) ? 5'b10001 : (c == 9) ? 5'b00110 : 5'b00000;
      e_rd = (c <= 8) ? 32'hCAFE_F00D : 32'hDEAD_BEEF;
      @(negedge clk);
      n_vec++;
      if ({bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall} !== e_st) begin
        n_bad++;
        $display("FAIL timeout_status c%0d: got %b want %b", c,
                 {bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall}, e_st);
      end
      n_vec++;
      if (bus.mem_rdata !== e_rd) begin
        n_bad++;
        $display("FAIL timeout_rdata c%0d: got %h want %h", c, bus.mem_rdata, e_rd);
      end
      next_cycle();
    end
  endtask

  task automatic test_both_strobes();
    logic [4:0] e_st [4] = '{5'b00001, 5'b01001, 5'b00000, 5'b00000};
    logic       rw   [4] = '{1, 1, 1, 0};
    for (int c = 0; c < 4; c++) begin
      drive(rw[c], rw[c], 32'h0000_7002, 32'hBEEF_BEEF, 4'b0011, 0, c == 1, 32'h9999_9999);
      @(negedge clk);
      n_vec++;
      if ({bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall} !== e_st[c]) begin
        n_bad++;
        $display("FAIL both_strobes_status c%0d: got %b want %b", c,
                 {bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall}, e_st[c]);
      end
      n_vec++;
      if (bus.mem_rdata !== 32'hDEAD_BEEF) begin
        n_bad++;
        $display("FAIL both_strobes_rdata c%0d: got %h want deadbeef", c, bus.mem_rdata);
      end
      if (e_st[c][3]) begin
        n_vec++;
        if ({bus.avm_address, bus.avm_byteenable, bus.avm_writedata} !== {32'h0000_7000, 4'b0011, 32'hBEEF_BEEF}) begin
          n_bad++;
          $display("FAIL both_strobes_cmd c%0d: got %h/%h/%h want 00007000/3/beefbeef", c,
                   bus.avm_address, bus.avm_byteenable, bus.avm_writedata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  e_st [7] = '{5'b00001, 5'b01001, 5'b00000, 5'b00001, 5'b10001, 5'b00100, 5'b00000};
    logic        rd   [7] = '{0, 0, 0, 1, 1, 1, 0};
    logic        wr   [7] = '{1, 1, 1, 0, 0, 0, 0};
    int          n_rd = 0;
    int          n_wr = 0;
    logic [31:0] e_rd;
    logic [31:0] addr;
    for (int c = 0; c < 7; c++) begin
      addr = (c <= 2) ? 32'h0000_5000 : 32'h0000_5004;
      e_rd = (c <= 4) ? 32'hDEAD_BEEF : 32'h55AA_55AA;
      drive(rd[c], wr[c], addr, 32'h0102_0304, 4'hF, 0, c == 4, 32'h55AA_55AA);
      @(negedge clk);
      n_rd += int'(bus.avm_read);
      n_wr += int'(bus.avm_write);
      n_vec++;
      if ({bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall} !== e_st[c]) begin
        n_bad++;
        $display("FAIL b2b_status c%0d: got %b want %b", c,
                 {bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall}, e_st[c]);
      end
      n_vec++;
      if (bus.mem_rdata !== e_rd) begin
        n_bad++;
        $display("FAIL b2b_rdata c%0d: got %h want %h", c, bus.mem_rdata, e_rd);
      end
      if (e_st[c][4] | e_st[c][3]) begin
        n_vec++;
        if (bus.avm_address !== addr) begin
          n_bad++;
          $display("FAIL b2b_addr c%0d: got %h want %h", c, bus.avm_address, addr);
        end
      end
      next_cycle();
    end
    n_vec++;
    if ({n_rd, n_wr} !== {32'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL b2b_strobe_count: got rd=%0d wr=%0d want rd=1 wr=1", n_rd, n_wr);
    end
  endtask

  task automatic test_reset_mid();
    logic [103:0] obs;
    drive(0, 1, 32'h0000_6000, 32'h1357_2468, 4'hF, 1, 0, 32'h0);
    next_cycle();
    @(negedge clk);
    n_vec++;
    if ({bus.avm_write, bus.mem_stall} !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_mid_precond: got write=%b stall=%b want 1 1", bus.avm_write, bus.mem_stall);
    end
    #2 rst_b = 1'b0;
    #1;
    obs = {bus.avm_address, bus.avm_read, bus.avm_write, bus.avm_writedata,
           bus.avm_byteenable, bus.mem_rdata, bus.mem_vld, bus.mem_err};
    n_vec++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_async_clear: got %h want 0", obs);
    end
    drive(0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    #1;
    n_vec++;
    if (bus.mem_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_stall: got %b want 0", bus.mem_stall);
    end
    @(negedge clk);
    rst_b = 1'b1;
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h7777_7777);
      @(negedge clk);
      n_vec++;
      if ({bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall, bus.mem_rdata} !== 37'h0) begin
        n_bad++;
        $display("FAIL rst_mid_stray_rdv c%0d: got status %b rdata %h want 00000 00000000", c,
                 {bus.avm_read, bus.avm_write, bus.mem_vld, bus.mem_err, bus.mem_stall}, bus.mem_rdata);
      end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_resp_read();
    test_timeout();
    test_both_strobes();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
